// File: rtl/pu_out_packer.sv
// pu_out_packer: buffers PU result words and serializes them into
// 64-bit output-buffer beats, tracking per-layer word counts.
module pu_out_packer #(
    parameter int NUM_PE     = 8,
    parameter int OP_WIDTH   = 16,
    parameter int DATA_WIDTH = NUM_PE * OP_WIDTH,
    parameter int BUF_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  layer_start,
    input  logic [COUNT_W-1:0]    expected_writes,
    input  logic                  pu_write_req,
    input  logic [DATA_WIDTH-1:0] pu_write_data,
    output logic                  pu_write_ready,
    output logic                  buffer_write_req,
    output logic [BUF_WIDTH-1:0]  buffer_write_data,
    input  logic                  buffer_write_full,
    output logic [COUNT_W-1:0]    write_count,
    output logic                  layer_done,
    output logic                  overflow
);

    localparam int BEATS = DATA_WIDTH / BUF_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [COUNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] head;
    logic [AW:0]           wptr, rptr, wptr_nx, rptr_nx;
    logic [AW-1:0]         waddr;
    logic [BW-1:0]         beat;
    logic [COUNT_W-1:0]    exp_q, emitted, em_nx;
    logic                  full, empty, push, pop, last_beat;
    logic                  zero_layer;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    assign pu_write_ready = !full;

    // A word arriving with layer_start lands in the freshly flushed FIFO.
    assign push  = pu_write_req && (pu_write_ready || layer_start);
    assign waddr = layer_start ? '0 : wptr[AW-1:0];

    assign buffer_write_req = !empty && !buffer_write_full &&
                              (state != IDLE);
    assign last_beat = (beat == BW'(BEATS - 1));
    assign pop       = buffer_write_req && last_beat;
    assign head      = mem[rptr[AW-1:0]];

    assign buffer_write_data = buffer_write_req ?
        head[int'(beat) * BUF_WIDTH +: BUF_WIDTH] : '0;

    assign zero_layer = (expected_writes == '0) && !pu_write_req;

    // Next pointer / emitted values, shared by storage and FSM.
    always_comb begin
        wptr_nx = wptr;
        rptr_nx = rptr;
        em_nx   = emitted;
        if (layer_start) begin
            rptr_nx = '0;
            wptr_nx = (AW + 1)'(push);
            em_nx   = '0;
        end else begin
            if (push)
                wptr_nx = wptr + 1'b1;
            if (pop) begin
                rptr_nx = rptr + 1'b1;
                if (emitted != CMAX)
                    em_nx = emitted + 1'b1;
            end
        end
    end

    // FIFO word storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[waddr] <= pu_write_data;
    end

    // Pointers, beat index, counters and layer FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            beat        <= '0;
            exp_q       <= '0;
            emitted     <= '0;
            write_count <= '0;
            layer_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wptr    <= wptr_nx;
            rptr    <= rptr_nx;
            emitted <= em_nx;
            if (layer_start) begin
                beat        <= '0;
                exp_q       <= expected_writes;
                write_count <= COUNT_W'(push);
                overflow    <= 1'b0;
                layer_done  <= zero_layer;
                state       <= zero_layer ? DONE : RUN;
            end else begin
                if (buffer_write_req)
                    beat <= last_beat ? '0 : beat + BW'(1);
                if (push && write_count != CMAX)
                    write_count <= write_count + 1'b1;
                if ((pu_write_req && !pu_write_ready) ||
                    (push && state == DONE))
                    overflow <= 1'b1;
                unique case (state)
                    IDLE: ;
                    RUN: begin
                        if (em_nx >= exp_q && wptr_nx == rptr_nx) begin
                            state      <= DONE;
                            layer_done <= 1'b1;
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pu_out_packer.sv
// tb_pu_out_packer: directed stimulus with a beat scoreboard;
// a negedge monitor pops expected beats as the DUT emits them.
module tb_pu_out_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         layer_start;
    logic [19:0]  expected_writes;
    logic         pu_write_req;
    logic [127:0] pu_write_data;
    logic         pu_write_ready;
    logic         buffer_write_req;
    logic [63:0]  buffer_write_data;
    logic         buffer_write_full;
    logic [19:0]  write_count;
    logic         layer_done;
    logic         overflow;

    int          checks = 0;
    int          errors = 0;
    int          beats_seen = 0;
    logic [63:0] sb [$];

    pu_out_packer dut (
        .clk               (clk),
        .reset             (reset),
        .layer_start       (layer_start),
        .expected_writes   (expected_writes),
        .pu_write_req      (pu_write_req),
        .pu_write_data     (pu_write_data),
        .pu_write_ready    (pu_write_ready),
        .buffer_write_req  (buffer_write_req),
        .buffer_write_data (buffer_write_data),
        .buffer_write_full (buffer_write_full),
        .write_count       (write_count),
        .layer_done        (layer_done),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mkword(input int w);
        logic [127:0] r;
        for (int l = 0; l < 8; l++)
            r[l*16 +: 16] = 16'(w * 8 + l);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int w);
        logic [127:0] d;
        d = mkword(w);
        sb.push_back(d[63:0]);
        sb.push_back(d[127:64]);
    endtask

    task automatic push_word(input int w, input bit keep);
        pu_write_req  = 1'b1;
        pu_write_data = mkword(w);
        if (keep)
            expect_word(w);
        tick();
        pu_write_req = 1'b0;
    endtask

    task automatic start(input int exp);
        layer_start     = 1'b1;
        expected_writes = 20'(exp);
        tick();
        layer_start = 1'b0;
    endtask

    task automatic wait_drain;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0)
                break;
            @(negedge clk);
            #1;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: every emitted beat must match the queue head.
    always @(negedge clk) begin
        if (!reset && buffer_write_full) begin
            checks++;
            if (buffer_write_req) begin
                errors++;
                $display("FAIL req_while_full: got 1 expected 0");
            end
        end
        if (!reset && buffer_write_req) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h expected none",
                         buffer_write_data);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                beats_seen++;
                if (buffer_write_data !== e) begin
                    errors++;
                    $display("FAIL beat_data: got %h expected %h",
                             buffer_write_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        reset             = 1'b1;
        layer_start       = 1'b0;
        expected_writes   = '0;
        pu_write_req      = 1'b0;
        pu_write_data     = '0;
        buffer_write_full = 1'b0;
        tick();
        tick();
        chk("rst_ready", 64'(pu_write_ready), 64'd1);
        chk("rst_req", 64'(buffer_write_req), 64'd0);
        chk("rst_data", buffer_write_data, 64'd0);
        chk("rst_count", 64'(write_count), 64'd0);
        chk("rst_done", 64'(layer_done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        tick();

        // Basic stream of three words.
        start(3);
        for (int w = 0; w < 3; w++)
            push_word(w, 1'b1);
        wait_drain();
        chk("basic_done_early", 64'(layer_done), 64'd0);
        @(negedge clk);
        #1;
        chk("basic_done", 64'(layer_done), 64'd1);
        chk("basic_count", 64'(write_count), 64'd3);

        // Backpressure in the middle of the second word.
        start(2);
        base = beats_seen;
        push_word(10, 1'b1);
        push_word(11, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (beats_seen >= base + 3)
                break;
            @(negedge clk);
            #1;
        end
        chk("bp_beats_before", 64'(beats_seen - base), 64'd3);
        buffer_write_full = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("bp_stalled", 64'(beats_seen - base), 64'd3);
        buffer_write_full = 1'b0;
        wait_drain();
        @(negedge clk);
        #1;
        chk("bp_done", 64'(layer_done), 64'd1);
        chk("bp_count", 64'(write_count), 64'd2);

        // Overflow: fifth word dropped while output is full.
        buffer_write_full = 1'b1;
        start(4);
        for (int w = 20; w < 24; w++)
            push_word(w, 1'b1);
        chk("ovf_ready", 64'(pu_write_ready), 64'd0);
        chk("ovf_before", 64'(overflow), 64'd0);
        push_word(24, 1'b0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(write_count), 64'd4);
        buffer_write_full = 1'b0;
        wait_drain();
        @(negedge clk);
        #1;
        chk("ovf_done", 64'(layer_done), 64'd1);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Restart mid-beat with two words buffered.
        buffer_write_full = 1'b1;
        push_word(30, 1'b1);
        push_word(31, 1'b1);
        buffer_write_full = 1'b0;
        tick();
        buffer_write_full = 1'b1;
        chk("rs_one_beat", 64'(sb.size()), 64'd3);
        sb.delete();
        layer_start     = 1'b1;
        expected_writes = 20'd1;
        pu_write_req    = 1'b1;
        pu_write_data   = mkword(40);
        expect_word(40);
        tick();
        layer_start  = 1'b0;
        pu_write_req = 1'b0;
        chk("rs_count", 64'(write_count), 64'd1);
        chk("rs_ovf", 64'(overflow), 64'd0);
        chk("rs_done", 64'(layer_done), 64'd0);
        buffer_write_full = 1'b0;
        wait_drain();
        @(negedge clk);
        #1;
        chk("rs_done_end", 64'(layer_done), 64'd1);

        // Zero-length layer.
        start(0);
        chk("zero_done", 64'(layer_done), 64'd1);
        repeat (4) tick();
        chk("zero_count", 64'(write_count), 64'd0);
        chk("zero_req", 64'(buffer_write_req), 64'd0);

        // Asynchronous reset mid-beat.
        layer_start     = 1'b1;
        expected_writes = 20'd1;
        pu_write_req    = 1'b1;
        pu_write_data   = mkword(50);
        tick();
        layer_start  = 1'b0;
        pu_write_req = 1'b0;
        chk("ar_req_pre", 64'(buffer_write_req), 64'd1);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("ar_req", 64'(buffer_write_req), 64'd0);
        chk("ar_data", buffer_write_data, 64'd0);
        chk("ar_ready", 64'(pu_write_ready), 64'd1);
        chk("ar_count", 64'(write_count), 64'd0);
        chk("ar_done", 64'(layer_done), 64'd0);
        chk("ar_ovf", 64'(overflow), 64'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("ar_idle_req", 64'(buffer_write_req), 64'd0);
        chk("final_sb", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
